// File: rtl/nixie_scan_driver.sv
// Multiplexed nixie driver. It converts NUM_PAIRS binary fields (0..99) into BCD
// digit pairs and scans them one tube at a time onto a shared cathode bus.
// Each tube slot starts with an anti-ghost blanking gap, and the lit part of the
// slot is gated by a PWM duty setting. The driver also supports per-pair blanking,
// leading-zero suppression on the top pair, and a cathode anti-poisoning sweep.
// Internal slot/count position leads the registered outputs by one clock.
module nixie_scan_driver #(
   parameter int NUM_PAIRS      = 3,
   parameter int DWELL_CYCLES   = 100000,
   parameter int BLANK_CYCLES   = 2000,
   parameter int PWM_BITS       = 4,
   parameter int CP_STEP_FRAMES = 50,
   parameter int LZB_TOP        = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7*NUM_PAIRS-1:0] pairValue,
   input  logic                   load,
   input  logic [PWM_BITS-1:0]    brightness,
   input  logic [NUM_PAIRS-1:0]   blankMask,
   input  logic                   cpStart,
   output logic [2*NUM_PAIRS-1:0] nixieEnable,
   output logic [3:0]             nixieDigit,
   output logic                   frameStart,
   output logic                   cpBusy
);

   localparam int NT        = 2 * NUM_PAIRS;
   localparam int PW        = 7 * NUM_PAIRS;
   localparam int ON_CYCLES = DWELL_CYCLES - BLANK_CYCLES;
   // Slice length; ON_CYCLES must be at least 2**PWM_BITS so each slice is >= 1 cycle.
   localparam int SL        = ON_CYCLES >> PWM_BITS;
   localparam int CW        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int TW        = (NT > 1) ? $clog2(NT) : 1;
   localparam int SW        = (SL > 1) ? $clog2(SL) : 1;
   localparam int FW        = (CP_STEP_FRAMES > 1) ? $clog2(CP_STEP_FRAMES) : 1;

   localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
   localparam logic [TW-1:0] SLOT_LAST = TW'(NT - 1);
   localparam logic [SW-1:0] SUB_LAST  = SW'(SL - 1);
   localparam logic [FW-1:0] STEP_LAST = FW'(CP_STEP_FRAMES - 1);
   localparam logic [3:0]    DIGIT_OFF = 4'hF;

   typedef enum logic {ST_BLANK, ST_ON} slot_state_t;

   slot_state_t         state, state_next;
   logic [CW-1:0]       cnt, cnt_next;
   logic [TW-1:0]       slot;
   logic [SW-1:0]       slice_sub;
   logic [PWM_BITS:0]   slice_idx;
   logic [PWM_BITS-1:0] bri_q, bri_cur;
   logic [PW-1:0]       pend_q, disp_q, src;
   logic                cp_active, cp_active_n, cp_busy_n;
   logic [3:0]          cp_digit, cp_digit_n;
   logic [FW-1:0]       cp_frames, cp_frames_n;
   logic                slot_start, frame_tick, lit;
   logic [6:0]          pair_v;
   logic                pair_blank, pair_top;
   logic [3:0]          tens, ones, digit_new, digit_cur;
   logic [NT-1:0]       en_d;

   assign slot_start = (cnt == '0);
   assign frame_tick = slot_start && (slot == '0);
   assign cnt_next   = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

   // Slot position: cycle counter within the slot and tube index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         slot <= '0;
      end else begin
         // NOTE: sequential state uses <= so every register samples pre-edge values.
         cnt <= cnt_next;
         if (cnt == CNT_LAST)
            slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
      end
   end

   // Slot FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_BLANK;
      else     state <= state_next;
   end

   // Slot FSM next state: the blanking gap covers the first BLANK_CYCLES counts.
   always_comb begin
      state_next = (cnt_next < BLANK_END) ? ST_BLANK : ST_ON;
   end

   // PWM slice tracker: slice index advances every SL cycles while ON, saturating past the top.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slice_sub <= '0;
         slice_idx <= '0;
      end else if (state == ST_ON && cnt != CNT_LAST) begin
         if (slice_sub == SUB_LAST) begin
            slice_sub <= '0;
            if (!slice_idx[PWM_BITS]) slice_idx <= slice_idx + 1'b1;
         end else begin
            slice_sub <= slice_sub + 1'b1;
         end
      end else begin
         slice_sub <= '0;
         slice_idx <= '0;
      end
   end

   // Sweep sequencing: arm on request, start/step/finish only on frame boundaries.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      cp_busy_n   = cpBusy;
      cp_active_n = cp_active;
      cp_digit_n  = cp_digit;
      cp_frames_n = cp_frames;
      if (frame_tick) begin
         if (cp_active) begin
            if (cp_frames == STEP_LAST) begin
               cp_frames_n = '0;
               if (cp_digit == 4'd9) begin
                  cp_active_n = 1'b0;
                  cp_busy_n   = 1'b0;
               end else begin
                  cp_digit_n = cp_digit + 4'd1;
               end
            end else begin
               cp_frames_n = cp_frames + 1'b1;
            end
         end else if (cpBusy) begin
            cp_active_n = 1'b1;
            cp_digit_n  = 4'd0;
            cp_frames_n = '0;
         end
      end
      if (cpStart && !cpBusy) cp_busy_n = 1'b1;
   end

   // Sweep registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpBusy    <= 1'b0;
         cp_active <= 1'b0;
         cp_digit  <= 4'd0;
         cp_frames <= '0;
      end else begin
         cpBusy    <= cp_busy_n;
         cp_active <= cp_active_n;
         cp_digit  <= cp_digit_n;
         cp_frames <= cp_frames_n;
      end
   end

   // Pending capture and frame-synchronous display update (value 127 reads as blank).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: these value registers are reset explicitly so the tubes start dark.
         pend_q <= '1;
         disp_q <= '1;
      end else begin
         if (load)       pend_q <= pairValue;
         if (frame_tick) disp_q <= pend_q;
      end
   end

   // Digit for the current tube; at the frame boundary read pending, which display takes now.
   always_comb begin
      src        = frame_tick ? pend_q : disp_q;
      pair_v     = 7'd127;
      pair_blank = 1'b0;
      pair_top   = 1'b0;
      for (int p = 0; p < NUM_PAIRS; p++) begin
         if (p == int'(slot >> 1)) begin
            pair_v     = src[p*7 +: 7];
            pair_blank = blankMask[p];
            pair_top   = (p == NUM_PAIRS - 1);
         end
      end
      tens      = 4'(pair_v / 7'd10);
      ones      = 4'(pair_v % 7'd10);
      digit_new = DIGIT_OFF;
      if (cp_active_n)
         digit_new = cp_digit_n;
      else if (pair_v > 7'd99 || pair_blank)
         digit_new = DIGIT_OFF;
      else if (slot[0])
         digit_new = (LZB_TOP != 0 && pair_top && tens == 4'd0) ? DIGIT_OFF : tens;
      else
         digit_new = ones;
   end

   // Slot FSM outputs: enable the slot's tube in ON slices up to the latched brightness.
   always_comb begin
      digit_cur = slot_start ? digit_new : nixieDigit;
      bri_cur   = slot_start ? (cp_active_n ? '1 : brightness) : bri_q;
      lit       = (state == ST_ON) && (slice_idx <= {1'b0, bri_cur}) &&
                  (digit_cur != DIGIT_OFF);
      en_d      = '0;
      for (int t = 0; t < NT; t++)
         en_d[t] = lit && (int'(slot) == t);
   end

   // Registered outputs plus the per-slot brightness latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nixieEnable <= '0;
         nixieDigit  <= DIGIT_OFF;
         frameStart  <= 1'b0;
         bri_q       <= '0;
      end else begin
         nixieEnable <= en_d;
         frameStart  <= frame_tick;
         if (slot_start) begin
            nixieDigit <= digit_new;
            bri_q      <= bri_cur;
         end
      end
   end

endmodule

// File: tb/tb_nixie_scan_driver.sv
// Randomised and directed bench for nixie_scan_driver. It captures whole frames,
// starting at frameStart, and compares every tube's digit and enable window
// against a behavioural model of the display rules.
module tb_nixie_scan_driver;

   localparam int NUM_PAIRS = 3;
   localparam int DWELL     = 40;
   localparam int BLANK     = 8;
   localparam int PWM       = 2;
   localparam int CPF       = 2;
   localparam int LZB       = 1;
   localparam int NT        = 2 * NUM_PAIRS;
   localparam int FRAME     = NT * DWELL;
   localparam int SL        = (DWELL - BLANK) >> PWM;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [7*NUM_PAIRS-1:0] pairValue;
   logic                   load;
   logic [PWM-1:0]         brightness;
   logic [NUM_PAIRS-1:0]   blankMask;
   logic                   cpStart;
   logic [NT-1:0]          nixieEnable;
   logic [3:0]             nixieDigit;
   logic                   frameStart;
   logic                   cpBusy;

   nixie_scan_driver #(
      .NUM_PAIRS(NUM_PAIRS), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK),
      .PWM_BITS(PWM), .CP_STEP_FRAMES(CPF), .LZB_TOP(LZB)
   ) dut (
      .clk(clk), .rst(rst), .pairValue(pairValue), .load(load),
      .brightness(brightness), .blankMask(blankMask), .cpStart(cpStart),
      .nixieEnable(nixieEnable), .nixieDigit(nixieDigit),
      .frameStart(frameStart), .cpBusy(cpBusy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state: what the display should show.
   int                   model_vals[NUM_PAIRS];
   logic [NUM_PAIRS-1:0] model_mask;
   int                   model_bri;
   int                   model_cp;   // sweep digit, or -1 for normal display

   // One captured frame.
   logic [3:0]       cap_digit[NT];
   logic [DWELL-1:0] cap_mask[NT];
   int               cap_onehot_err, cap_glitch, cap_fs_extra;
   logic [FRAME-1:0] cap_busy;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [3:0] exp_digit(int t);
      int p = t / 2;
      int v = model_vals[p];
      if (model_cp >= 0) return 4'(model_cp);
      if (v > 99 || model_mask[p]) return 4'hF;
      if (t % 2 == 1) begin
         if (LZB == 1 && p == NUM_PAIRS - 1 && v / 10 == 0) return 4'hF;
         return 4'(v / 10);
      end
      return 4'(v % 10);
   endfunction

   function automatic logic [DWELL-1:0] exp_mask(int t);
      logic [DWELL-1:0] m = '0;
      int b = (model_cp >= 0) ? (2**PWM - 1) : model_bri;
      if (exp_digit(t) == 4'hF) return m;
      for (int c = BLANK; c < DWELL; c++) begin
         int s = (c - BLANK) / SL;
         if (s <= b && s < 2**PWM) m[c] = 1'b1;
      end
      return m;
   endfunction

   // Advance to the next frameStart cycle (sampled on the falling edge).
   task automatic wait_frame_start();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frameStart && n < 2 * FRAME);
      if (!frameStart) check("frame_start_timeout", frameStart, 1'b1);
   endtask

   task automatic measure_period(input string tag);
      int n = 0;
      wait_frame_start();
      do begin
         @(negedge clk);
         n++;
      end while (!frameStart && n < 2 * FRAME);
      check(tag, n, FRAME);
   endtask

   // Record one frame, starting at the current frameStart cycle. Optionally pulse
   // load / cpStart for one cycle at the given frame offsets (< FRAME-1).
   task automatic capture(input int load_at, input int cp_at);
      cap_onehot_err = 0;
      cap_glitch     = 0;
      cap_fs_extra   = 0;
      for (int c = 0; c < FRAME; c++) begin
         int k = c / DWELL;
         int o = c % DWELL;
         if (c > 0) @(negedge clk);
         if (o == 0) cap_digit[k] = nixieDigit;
         else if (nixieDigit !== cap_digit[k]) cap_glitch++;
         cap_mask[k][o] = nixieEnable[k];
         if ((nixieEnable & ~(NT'(1) << k)) != '0) cap_onehot_err++;
         if (c > 0 && frameStart) cap_fs_extra++;
         cap_busy[c] = cpBusy;
         load    = (c == load_at);
         cpStart = (c == cp_at);
      end
      load    = 1'b0;
      cpStart = 1'b0;
   endtask

   task automatic check_frame(input string tag);
      for (int t = 0; t < NT; t++) begin
         check($sformatf("%s_digit%0d", tag, t), cap_digit[t], exp_digit(t));
         check($sformatf("%s_enable%0d", tag, t), cap_mask[t], exp_mask(t));
      end
      check({tag, "_onehot"}, cap_onehot_err, 0);
      check({tag, "_digit_hold"}, cap_glitch, 0);
      check({tag, "_single_fs"}, cap_fs_extra, 0);
   endtask

   task automatic set_model(input int v2, input int v1, input int v0);
      model_vals[0] = v0;
      model_vals[1] = v1;
      model_vals[2] = v2;
   endtask

   task automatic apply_and_check(input string tag, input int v2, input int v1, input int v0,
                                  input int bri, input logic [NUM_PAIRS-1:0] mask);
      @(negedge clk);
      brightness = PWM'(bri);
      blankMask  = mask;
      pairValue  = {7'(v2), 7'(v1), 7'(v0)};
      load       = 1'b1;
      @(negedge clk);
      load       = 1'b0;
      set_model(v2, v1, v0);
      model_bri  = bri;
      model_mask = mask;
      wait_frame_start();
      wait_frame_start();
      capture(-1, -1);
      check_frame(tag);
   endtask

   function automatic int rand_val();
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 127))
                                         : int'($urandom_range(0, 99));
   endfunction

   initial begin
      rst = 1'b1; pairValue = '0; load = 1'b0; brightness = '0; blankMask = '0; cpStart = 1'b0;
      set_model(127, 127, 127);
      model_mask = '0;
      model_bri  = 0;
      model_cp   = -1;

      repeat (3) @(negedge clk);
      check("reset_enable", nixieEnable, '0);
      check("reset_digit", nixieDigit, 4'hF);
      check("reset_frame_start", frameStart, 1'b0);
      check("reset_cp_busy", cpBusy, 1'b0);
      rst = 1'b0;

      measure_period("frame_period");
      capture(-1, -1);
      check_frame("idle");

      apply_and_check("load_235907", 23, 59, 7, 3, 3'b000);
      apply_and_check("bri1", 23, 59, 7, 1, 3'b000);
      apply_and_check("bri0", 23, 59, 7, 0, 3'b000);
      apply_and_check("lzb_top", 5, 59, 7, 3, 3'b000);
      apply_and_check("over99", 5, 59, 120, 3, 3'b000);
      apply_and_check("blank_mask", 23, 59, 7, 2, 3'b010);

      for (int i = 0; i < 6; i++)
         apply_and_check($sformatf("rand%0d", i), rand_val(), rand_val(), rand_val(),
                         int'($urandom_range(0, 3)), NUM_PAIRS'($urandom_range(0, 7)));

      // load in the frameStart cycle: this frame keeps the old value, the next shows the new one
      apply_and_check("pre_coinc", 12, 34, 56, 3, 3'b000);
      wait_frame_start();
      pairValue = {7'd78, 7'd90, 7'd1};
      capture(0, -1);
      check_frame("coinc_old");
      set_model(78, 90, 1);
      wait_frame_start();
      capture(-1, -1);
      check_frame("coinc_new");

      // Anti-poisoning sweep over a display that would otherwise be partly blank and dim
      apply_and_check("pre_sweep", 5, 59, 120, 0, 3'b010);
      wait_frame_start();
      capture(-1, 10);
      check_frame("cp_request");
      check("cp_busy_before", cap_busy[10], 1'b0);
      check("cp_busy_rise", cap_busy[11], 1'b1);
      pairValue = {7'd42, 7'd8, 7'd91};
      for (int f = 0; f < 10 * CPF; f++) begin
         wait_frame_start();
         capture((f == 3) ? 50 : -1, (f == 5) ? 100 : -1);
         model_cp = f / CPF;
         check_frame($sformatf("sweep%0d", f));
         check($sformatf("sweep%0d_busy", f), &cap_busy, 1'b1);
      end
      model_cp = -1;
      set_model(42, 8, 91);
      wait_frame_start();
      capture(-1, -1);
      check_frame("post_sweep");
      check("cp_busy_drop", cap_busy[0], 1'b0);
      wait_frame_start();
      capture(-1, -1);
      check_frame("post_sweep2");
      check("cp_busy_idle", |cap_busy, 1'b0);

      // Reset while the sweep shows digit 4
      brightness = 2'd2;
      wait_frame_start();
      capture(-1, 10);
      for (int f = 0; f <= 4 * CPF; f++) begin
         wait_frame_start();
         capture(-1, -1);
      end
      model_cp = 4;
      check_frame("abort_digit4");
      wait_frame_start();
      repeat (60) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_enable", nixieEnable, '0);
      check("abort_digit", nixieDigit, 4'hF);
      check("abort_frame_start", frameStart, 1'b0);
      check("abort_cp_busy", cpBusy, 1'b0);
      repeat (3) @(negedge clk);
      check("abort_hold_digit", nixieDigit, 4'hF);
      check("abort_hold_busy", cpBusy, 1'b0);
      rst = 1'b0;

      model_cp = -1;
      set_model(127, 127, 127);
      measure_period("after_abort_period");
      capture(-1, -1);
      check_frame("after_abort");
      check("after_abort_busy", |cap_busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
